// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port,
// and the IF/ID pipeline register outputs consumed by decode.
// Handshake: there is no valid/ready pair here; stall and flush are level
// controls sampled on every rising clk edge, and ifid_valid qualifies the
// IF/ID register contents on the cycle they are presented.
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic [63:0] branch_target;
    logic [63:0] inst_addr;
    logic [31:0] inst_data;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instruction;
    logic        ifid_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;
    logic [1:0]  fsm_state;

    // Fetch stage side: drives memory address and IF/ID contents.
    modport master (
        input  stall, flush, branch_target, inst_data,
        output inst_addr, ifid_pc, ifid_instruction, ifid_valid,
               halted, misaligned, fetch_count, fsm_state
    );

    // Environment side: hazard unit, EX stage, instruction memory, decode.
    modport slave (
        output stall, flush, branch_target, inst_data,
        input  inst_addr, ifid_pc, ifid_instruction, ifid_valid,
               halted, misaligned, fetch_count, fsm_state
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register,
// stall/redirect handling and end-of-program halt. The FSM state is
// exposed on bus.fsm_state (0=RUN, 1=HALT, 2=ERR).
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] END_PC   = 64'd148,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_insn_q, ifid_insn_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halted_q, halted_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] count_q, count_d;
    logic        target_misaligned;

    assign target_misaligned = (bus.branch_target[1:0] != 2'b00);

    // Register all architectural state; reset discards IF/ID immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 64'h0;
            ifid_insn_q  <= NOP_INSN;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
            count_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_insn_q  <= ifid_insn_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    // Next-state logic; priority is ERR > flush > stall > normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_insn_d  = ifid_insn_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        misaligned_d = misaligned_q;
        count_d      = count_q;

        case (state_q)
            ST_RUN, ST_HALT: begin
                if (bus.flush) begin
                    // Redirect always squashes IF/ID and leaves HALT.
                    ifid_pc_d    = 64'h0;
                    ifid_insn_d  = NOP_INSN;
                    ifid_valid_d = 1'b0;
                    halted_d     = 1'b0;
                    if (target_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = ST_ERR;
                    end else begin
                        pc_d    = bus.branch_target;
                        state_d = ST_RUN;
                    end
                end else if (bus.stall) begin
                    // Hold PC, IF/ID and the counter.
                end else if (state_q == ST_HALT || pc_q >= END_PC) begin
                    ifid_pc_d    = 64'h0;
                    ifid_insn_d  = NOP_INSN;
                    ifid_valid_d = 1'b0;
                    halted_d     = 1'b1;
                    state_d      = ST_HALT;
                end else begin
                    ifid_pc_d    = pc_q;
                    ifid_insn_d  = bus.inst_data;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 64'd4;
                    count_d      = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
                end
            end
            default: begin
                // ERR: bubble forever, only reset leaves.
                ifid_pc_d    = 64'h0;
                ifid_insn_d  = NOP_INSN;
                ifid_valid_d = 1'b0;
                halted_d     = 1'b0;
                misaligned_d = 1'b1;
                state_d      = ST_ERR;
            end
        endcase
    end

    assign bus.inst_addr        = pc_q;
    assign bus.ifid_pc          = ifid_pc_q;
    assign bus.ifid_instruction = ifid_insn_q;
    assign bus.ifid_valid       = ifid_valid_q;
    assign bus.halted           = halted_q;
    assign bus.misaligned       = misaligned_q;
    assign bus.fetch_count      = count_q;
    assign bus.fsm_state        = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 37-word program in a combinational
// memory model, one task per scenario, inline comparisons.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;
    logic [31:0] mem [0:36];

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-program reads return a marker.
    always_comb begin
        if (bus.inst_addr < 64'd148)
            bus.inst_data = mem[bus.inst_addr[7:2]];
        else
            bus.inst_data = 32'hDEADBEEF;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.branch_target = 64'h0;
        reset_n = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.inst_addr !== 64'h0) begin $display("FAIL reset_addr got=%h exp=0", bus.inst_addr); n_fail++; end
        n_cmp++; if (bus.ifid_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", bus.ifid_valid); n_fail++; end
        n_cmp++; if (bus.ifid_instruction !== NOP) begin $display("FAIL reset_insn got=%h exp=%h", bus.ifid_instruction, NOP); n_fail++; end
        n_cmp++; if ({bus.halted, bus.misaligned, bus.fetch_count} !== 34'h0) begin $display("FAIL reset_flags got=%b%b %0d exp=00 0", bus.halted, bus.misaligned, bus.fetch_count); n_fail++; end
        step();
        n_cmp++; if (bus.ifid_pc !== 64'h0 || bus.ifid_instruction !== 32'h00000913 || bus.ifid_valid !== 1'b1) begin $display("FAIL edge1 got pc=%h insn=%h v=%b exp pc=0 insn=00000913 v=1", bus.ifid_pc, bus.ifid_instruction, bus.ifid_valid); n_fail++; end
        step();
        n_cmp++; if (bus.ifid_pc !== 64'h4 || bus.ifid_instruction !== 32'h00500993) begin $display("FAIL edge2 got pc=%h insn=%h exp pc=4 insn=00500993", bus.ifid_pc, bus.ifid_instruction); n_fail++; end
        // Asynchronous reset mid-operation clears IF/ID before any edge.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.ifid_valid !== 1'b0 || bus.inst_addr !== 64'h0) begin $display("FAIL async_reset got v=%b addr=%h exp v=0 addr=0", bus.ifid_valid, bus.inst_addr); n_fail++; end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) step();
        n_cmp++; if (bus.ifid_pc !== 64'h8 || bus.fetch_count !== 32'd3) begin $display("FAIL pre_stall got pc=%h cnt=%0d exp pc=8 cnt=3", bus.ifid_pc, bus.fetch_count); n_fail++; end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.inst_addr !== 64'd12 || bus.ifid_pc !== 64'h8 || bus.fetch_count !== 32'd3 || bus.ifid_valid !== 1'b1) begin $display("FAIL stall_hold[%0d] got addr=%0d pc=%h cnt=%0d v=%b exp 12 8 3 1", i, bus.inst_addr, bus.ifid_pc, bus.fetch_count, bus.ifid_valid); n_fail++; end
        end
        bus.stall = 1'b0;
        step();
        n_cmp++; if (bus.ifid_pc !== 64'd12 || bus.ifid_instruction !== mem[3] || bus.fetch_count !== 32'd4) begin $display("FAIL stall_resume got pc=%h insn=%h cnt=%0d exp pc=c insn=%h cnt=4", bus.ifid_pc, bus.ifid_instruction, bus.fetch_count, mem[3]); n_fail++; end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (12) step();
        n_cmp++; if (bus.inst_addr !== 64'h30) begin $display("FAIL pre_flush_addr got=%h exp=30", bus.inst_addr); n_fail++; end
        bus.flush = 1'b1;
        bus.branch_target = 64'h28;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instruction !== NOP || bus.ifid_pc !== 64'h0 || bus.inst_addr !== 64'h28) begin $display("FAIL flush_bubble got v=%b insn=%h pc=%h addr=%h exp 0 00000013 0 28", bus.ifid_valid, bus.ifid_instruction, bus.ifid_pc, bus.inst_addr); n_fail++; end
        step();
        n_cmp++; if (bus.ifid_pc !== 64'h28 || bus.ifid_instruction !== 32'h00000493 || bus.ifid_valid !== 1'b1) begin $display("FAIL flush_target got pc=%h insn=%h v=%b exp 28 00000493 1", bus.ifid_pc, bus.ifid_instruction, bus.ifid_valid); n_fail++; end
        // Flush and stall together: flush wins.
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        bus.branch_target = 64'h10;
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        n_cmp++; if (bus.inst_addr !== 64'h10 || bus.ifid_valid !== 1'b0 || bus.ifid_instruction !== NOP) begin $display("FAIL flush_stall got addr=%h v=%b insn=%h exp 10 0 00000013", bus.inst_addr, bus.ifid_valid, bus.ifid_instruction); n_fail++; end
    endtask

    task automatic test_run_to_end();
        logic [63:0] exp_pc;
        logic [63:0] last_pc;
        logic [31:0] last_insn;
        int          edges;
        do_reset();
        exp_pc = 64'h0;
        last_pc = 64'hFFFF;
        last_insn = 32'h0;
        edges = 0;
        while (bus.halted !== 1'b1 && edges < 60) begin
            step();
            edges++;
            if (bus.ifid_valid === 1'b1) begin
                n_cmp++; if (bus.ifid_pc !== exp_pc || bus.ifid_instruction !== mem[exp_pc[7:2]]) begin $display("FAIL stream got pc=%h insn=%h exp pc=%h insn=%h", bus.ifid_pc, bus.ifid_instruction, exp_pc, mem[exp_pc[7:2]]); n_fail++; end
                last_pc = bus.ifid_pc;
                last_insn = bus.ifid_instruction;
                exp_pc = exp_pc + 64'd4;
            end
        end
        n_cmp++; if (edges !== 38) begin $display("FAIL halt_edge got=%0d exp=38", edges); n_fail++; end
        n_cmp++; if (last_pc !== 64'h90 || last_insn !== 32'hf8000ce3) begin $display("FAIL last_valid got pc=%h insn=%h exp 90 f8000ce3", last_pc, last_insn); n_fail++; end
        n_cmp++; if (bus.fetch_count !== 32'd37 || bus.halted !== 1'b1) begin $display("FAIL halt_count got cnt=%0d h=%b exp 37 1", bus.fetch_count, bus.halted); n_fail++; end
        repeat (2) step();
        n_cmp++; if (bus.inst_addr !== 64'd148 || bus.ifid_valid !== 1'b0 || bus.halted !== 1'b1 || bus.fetch_count !== 32'd37) begin $display("FAIL halt_bubbles got addr=%0d v=%b h=%b cnt=%0d exp 148 0 1 37", bus.inst_addr, bus.ifid_valid, bus.halted, bus.fetch_count); n_fail++; end
        bus.flush = 1'b1;
        bus.branch_target = 64'h0;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.halted !== 1'b0 || bus.inst_addr !== 64'h0 || bus.ifid_valid !== 1'b0) begin $display("FAIL halt_exit got h=%b addr=%h v=%b exp 0 0 0", bus.halted, bus.inst_addr, bus.ifid_valid); n_fail++; end
        step();
        n_cmp++; if (bus.ifid_pc !== 64'h0 || bus.ifid_instruction !== 32'h00000913 || bus.ifid_valid !== 1'b1) begin $display("FAIL refetch got pc=%h insn=%h v=%b exp 0 00000913 1", bus.ifid_pc, bus.ifid_instruction, bus.ifid_valid); n_fail++; end
    endtask

    task automatic test_misaligned();
        do_reset();
        repeat (2) step();
        bus.flush = 1'b1;
        bus.branch_target = 64'h2A;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.misaligned !== 1'b1 || bus.inst_addr !== 64'h8 || bus.ifid_valid !== 1'b0 || bus.fsm_state !== 2'd2) begin $display("FAIL misalign_enter got m=%b addr=%h v=%b st=%0d exp 1 8 0 2", bus.misaligned, bus.inst_addr, bus.ifid_valid, bus.fsm_state); n_fail++; end
        repeat (3) step();
        bus.flush = 1'b1;
        bus.branch_target = 64'h40;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.misaligned !== 1'b1 || bus.inst_addr !== 64'h8 || bus.ifid_valid !== 1'b0 || bus.fetch_count !== 32'd2) begin $display("FAIL misalign_sticky got m=%b addr=%h v=%b cnt=%0d exp 1 8 0 2", bus.misaligned, bus.inst_addr, bus.ifid_valid, bus.fetch_count); n_fail++; end
        do_reset();
        n_cmp++; if (bus.misaligned !== 1'b0 || bus.inst_addr !== 64'h0) begin $display("FAIL misalign_reset got m=%b addr=%h exp 0 0", bus.misaligned, bus.inst_addr); n_fail++; end
        step();
        n_cmp++; if (bus.ifid_pc !== 64'h0 || bus.ifid_instruction !== 32'h00000913 || bus.ifid_valid !== 1'b1) begin $display("FAIL misalign_restart got pc=%h insn=%h v=%b exp 0 00000913 1", bus.ifid_pc, bus.ifid_instruction, bus.ifid_valid); n_fail++; end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 37; i++) mem[i] = 32'h10000000 + i;
        mem[0]  = 32'h00000913;
        mem[1]  = 32'h00500993;
        mem[10] = 32'h00000493;
        mem[36] = 32'hf8000ce3;
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.branch_target = 64'h0;
        test_reset();
        test_stall();
        test_flush();
        test_run_to_end();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
